// File: rtl/inv_round_key.sv
// inv_round_key: sequential AES-128 decryption key scheduler; expands forward to round 10,
// then walks back to round 0, one key per accepted handshake.
module inv_round_key (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         busy,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   round_out
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
  state_t state, state_nxt;
  logic [127:0] k, k_fwd, k_bwd;
  logic [3:0] r;
  logic [31:0] w0, w1, w2, w3, p3, sb_in, t;
  logic [7:0] rc;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, v;
    s = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i == 4'd9 ? 8'h1b : i == 4'd10 ? 8'h36 : 8'h01 << (i - 4'd1);
  endfunction
  // one shared S-box: forward steps feed w3, backward steps feed the recovered old w3
  always_comb begin
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    sb_in = state == EMIT ? p3 : w3;
    rc = rcon(state == EMIT ? r : r + 4'd1);
    t = sub_word({sb_in[23:0], sb_in[31:24]}) ^ {rc, 24'h0};
    k_fwd = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    k_bwd = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE   ? (start ? EXPAND : IDLE)
              : state == EXPAND ? (r == 4'd9 ? EMIT : EXPAND)
              : state == EMIT   ? (key_ready && r == 4'd0 ? IDLE : EMIT)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      r <= '0;
    end else if (state == IDLE && start) begin
      k <= key_in;
      r <= '0;
    end else if (state == EXPAND) begin
      k <= k_fwd;
      r <= r + 4'd1;
    end else if (state == EMIT && key_ready && r != 4'd0) begin
      k <= k_bwd;
      r <= r - 4'd1;
    end
  end
  always_comb begin
    busy = state != IDLE;
    key_valid = state == EMIT;
    key_out = k;
    round_out = r;
  end
endmodule

// File: tb/tb_inv_round_key.sv
// tb_inv_round_key: scoreboard bench; a FIPS-197 style key-expansion model predicts every
// emitted round key, a negedge monitor checks each handshake transfer in order.
module tb_inv_round_key;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, key_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic busy, key_valid;
  logic [127:0] key_out;
  logic [3:0] round_out;
  int n_vec = 0, n_err = 0;
  typedef struct {logic [127:0] k; logic [3:0] r;} exp_t;
  exp_t sb[$];
  logic [127:0] rk [0:10];
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_round_key dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .busy(busy), .key_valid(key_valid), .key_out(key_out), .round_out(round_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sbx(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbx(w[31:24]), sbx(w[23:16]), sbx(w[15:8]), sbx(w[7:0])};
  endfunction

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i <= 10; i++) rk[i] = {w[4 * i], w[4 * i + 1], w[4 * i + 2], w[4 * i + 3]};
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_key: got %h round %0d expected none", key_out, round_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_key", key_out, e.k);
        chk("sb_round", 128'(round_out), 128'(e.r));
      end
    end
  end

  // start at edge N, optional foreign start pulse in EXPAND; returns just after edge N+10
  task automatic start_sched(input logic [127:0] key, input bit junk);
    model(key);
    for (int i = 10; i >= 0; i--) sb.push_back('{rk[i], 4'(i)});
    key_in = key;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = ~key;
    chk("busy_at_n", 128'(busy), 128'(1));
    for (int i = 1; i <= 10; i++) begin
      start = junk && i == 5;
      @(posedge clk); #1;
      if (i == 9) chk("valid_at_n9", 128'(key_valid), 128'(0));
    end
    start = 1'b0;
    chk("valid_at_n10", 128'(key_valid), 128'(1));
    chk("round_at_n10", 128'(round_out), 128'(10));
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 400 && busy; i++) begin
      key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    chk("drain_idle", 128'(busy), 128'(0));
    chk("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic wait_round(input logic [3:0] target);
    for (int i = 0; i < 20 && round_out != target; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_round", 128'(round_out), 128'(target));
  endtask

  initial begin
    logic [127:0] k;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_key", key_out, 128'(0));
    chk("rst_round", 128'(round_out), 128'(0));
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", 128'(busy), 128'(0));

    key_ready = 1'b1;
    start_sched(FIPS_KEY, 1'b0);
    chk("fips_r10", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    chk("fips_r9", key_out, 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r9_idx", 128'(round_out), 128'(9));
    repeat (8) @(posedge clk);
    #1;
    chk("fips_r1", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
    @(posedge clk); #1;
    chk("fips_r0", key_out, FIPS_KEY);
    chk("fips_r0_idx", 128'(round_out), 128'(0));
    start = 1'b1;
    key_in = 128'h0123456789abcdef0123456789abcdef;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fips_busy_n21", 128'(busy), 128'(0));
    chk("fips_valid_n21", 128'(key_valid), 128'(0));
    chk("fips_key_kept", key_out, FIPS_KEY);
    @(posedge clk); #1;
    chk("late_start_ignored", 128'(busy), 128'(0));
    chk("fips_empty", 128'(sb.size()), 128'(0));

    k = {$urandom, $urandom, $urandom, $urandom};
    key_ready = 1'b1;
    start_sched(k, 1'b1);
    wait_round(4'd7);
    key_ready = 1'b0;
    start = 1'b1;
    key_in = ~k;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("stall_key", key_out, rk[7]);
      chk("stall_round", 128'(round_out), 128'(7));
      chk("stall_valid", 128'(key_valid), 128'(1));
    end
    drain(1'b1);

    k = {$urandom, $urandom, $urandom, $urandom};
    key_ready = 1'b1;
    start_sched(k, 1'b0);
    wait_round(4'd4);
    rst = 1'b1;
    key_ready = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_valid", 128'(key_valid), 128'(0));
    chk("midrst_key", key_out, 128'(0));
    chk("midrst_round", 128'(round_out), 128'(0));
    rst = 1'b0;
    start_sched(128'(0), 1'b0);
    chk("zero_r10", key_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    drain(1'b0);
    chk("zero_r0_kept", key_out, 128'(0));

    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      key_ready = 1'($urandom_range(0, 1));
      start_sched(k, 1'(n % 2));
      drain(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
